// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED matrix PWM driver.
package led_pkg;

  localparam int unsigned DEF_ROWS = 4;
  localparam int unsigned DEF_COLS = 4;
  localparam int unsigned DEF_BITS = 4;

  // Electrical active levels of the matrix pins.
  localparam logic ANODE_ON   = 1'b0;
  localparam logic CATHODE_ON = 1'b1;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int unsigned LED_IDX_W(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Scan timing: prescaler, PWM slot, row and frame-end generation.
module led_scan_timer
  import led_pkg::*;
#(
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned NSLOT    = 17,
  parameter int unsigned SCAN_DIV = 32,
  localparam int unsigned PW = LED_IDX_W(SCAN_DIV),
  localparam int unsigned SW = LED_IDX_W(NSLOT),
  localparam int unsigned RW = LED_IDX_W(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_tick_c,
  output logic [SW-1:0] o_slot,
  output logic [RW-1:0] o_row,
  output logic          o_frame_end_c
);

  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_slot;
  logic [RW-1:0] r_row;
  logic          w_tick;
  logic          w_slot_last;
  logic          w_row_last;

  assign w_tick      = (r_presc == PW'(SCAN_DIV - 32'd1));
  assign w_slot_last = (r_slot == SW'(NSLOT - 32'd1));
  assign w_row_last  = (r_row == RW'(ROWS - 32'd1));

  assign o_tick_c      = w_tick;
  assign o_slot        = r_slot;
  assign o_row         = r_row;
  assign o_frame_end_c = w_tick & w_slot_last & w_row_last;

  // Prescaler wraps every SCAN_DIV clocks; slot and row advance on its tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_slot  <= '0;
      r_row   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_slot <= w_slot_last ? '0 : r_slot + SW'(1);
        if (w_slot_last) begin
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/led_matrix_pwm.sv
// Row-scanned LED matrix driver with per-LED PWM and a double-buffered frame store.
module led_matrix_pwm
  import led_pkg::*;
#(
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned BITS     = DEF_BITS,
  parameter int unsigned SCAN_DIV = 32,
  parameter int unsigned BLANK    = 2,
  localparam int unsigned AW = LED_IDX_W(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            swap_req,
  output logic            swap_ack,
  output logic            frame_sync,
  output logic [COLS-1:0] aled,
  output logic [ROWS-1:0] kled_tri
);

  localparam int unsigned NLED  = ROWS * COLS;
  localparam int unsigned NSLOT = BLANK + (32'd1 << BITS) - 32'd1;
  localparam int unsigned SW    = LED_IDX_W(NSLOT);
  localparam int unsigned RW    = LED_IDX_W(ROWS);

  logic [BITS-1:0] r_buf0 [NLED];
  logic [BITS-1:0] r_buf1 [NLED];
  logic            r_front_sel;
  logic            r_pend;
  logic [COLS-1:0] r_aled;
  logic [ROWS-1:0] r_kled;
  logic            r_swap_ack;
  logic            r_frame_sync;

  logic            w_tick;
  logic            w_frame_end;
  logic [SW-1:0]   w_slot;
  logic [RW-1:0]   w_row;
  logic            w_blank;
  logic [BITS-1:0] w_pwm;
  logic            w_wr_ok;
  logic            w_pend_any;
  logic            w_swap;
  logic [AW-1:0]   w_idx;
  logic [BITS-1:0] w_lvl;
  logic [COLS-1:0] w_aled_nx;
  logic [ROWS-1:0] w_kled_nx;

  led_scan_timer #(
    .ROWS     (ROWS),
    .NSLOT    (NSLOT),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .o_tick_c      (w_tick),
    .o_slot        (w_slot),
    .o_row         (w_row),
    .o_frame_end_c (w_frame_end)
  );

  // Leading slots of each row are dark to hide the row change.
  if (BLANK == 0) begin : g_no_blank
    assign w_blank = 1'b0;
  end else begin : g_blank
    assign w_blank = (32'(w_slot) < BLANK);
  end

  assign w_pwm      = BITS'(32'(w_slot) - BLANK);
  assign w_wr_ok    = wr_en & (32'(wr_addr) < NLED);
  assign w_pend_any = r_pend | swap_req;
  assign w_swap     = w_tick & w_frame_end & w_pend_any;

  // Writers only ever touch the hidden buffer; swap-cycle writes use the pre-swap selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NLED; i++) begin
        r_buf0[i] <= '0;
        r_buf1[i] <= '0;
      end
    end else if (w_wr_ok) begin
      if (r_front_sel) begin
        r_buf0[wr_addr] <= wr_data;
      end else begin
        r_buf1[wr_addr] <= wr_data;
      end
    end
  end

  // Sticky swap request, served by toggling the front select at a frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_front_sel <= 1'b0;
    end else if (w_swap) begin
      r_pend      <= 1'b0;
      r_front_sel <= ~r_front_sel;
    end else begin
      r_pend <= w_pend_any;
    end
  end

  // Pin levels for the current row/slot, taken from the front buffer.
  always_comb begin
    w_aled_nx = {COLS{~ANODE_ON}};
    w_kled_nx = {ROWS{~CATHODE_ON}};
    w_idx     = '0;
    w_lvl     = '0;
    if (!w_blank) begin
      w_kled_nx = {ROWS{~CATHODE_ON}} ^ (ROWS'(1) << w_row);
      for (int unsigned c = 0; c < COLS; c++) begin
        w_idx = AW'(32'(w_row) * COLS + c);
        w_lvl = r_front_sel ? r_buf1[w_idx] : r_buf0[w_idx];
        if (w_lvl > w_pwm) begin
          w_aled_nx[c] = ANODE_ON;
        end
      end
    end
  end

  // Output registers trail the scan counters by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aled       <= {COLS{~ANODE_ON}};
      r_kled       <= {ROWS{~CATHODE_ON}};
      r_swap_ack   <= 1'b0;
      r_frame_sync <= 1'b0;
    end else begin
      r_aled       <= w_aled_nx;
      r_kled       <= w_kled_nx;
      r_swap_ack   <= w_swap;
      r_frame_sync <= w_tick & w_frame_end;
    end
  end

  assign aled       = r_aled;
  assign kled_tri   = r_kled;
  assign swap_ack   = r_swap_ack;
  assign frame_sync = r_frame_sync;

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Self-checking bench: time-based reference model of the scanned, double-buffered display.
module tb_led_matrix_pwm;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int BITS      = 4;
  localparam int SCAN_DIV  = 2;
  localparam int BLANK     = 1;
  localparam int NLED      = ROWS * COLS;
  localparam int NSLOT     = BLANK + (1 << BITS) - 1;
  localparam int ROW_CLK   = SCAN_DIV * NSLOT;
  localparam int FRAME_CLK = ROWS * ROW_CLK;

  // Second instance: 3x4, 2-bit levels, no blanking, one clk per slot (12 LEDs, 4-bit address).
  localparam int O_ROW_CLK   = 3;
  localparam int O_FRAME_CLK = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_sync;
  logic [3:0] aled;
  logic [3:0] kled_tri;

  logic       o_wr_en;
  logic [3:0] o_wr_addr;
  logic [1:0] o_wr_data;
  logic       o_swap_req;
  logic       o_swap_ack;
  logic       o_frame_sync;
  logic [3:0] o_aled;
  logic [2:0] o_kled;

  int errors = 0;
  int checks = 0;

  int         t;
  logic [3:0] m_buf [2][NLED];
  int         m_sel;
  bit         m_pend;
  bit         oor_pend;
  bit         oor_swapped;
  int         n_ack;
  int         n_sync;
  int         lit [NLED];
  int         n_ack0;

  always #5 clk = ~clk;

  led_matrix_pwm #(
    .ROWS(ROWS), .COLS(COLS), .BITS(BITS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_sync(frame_sync),
    .aled(aled), .kled_tri(kled_tri)
  );

  led_matrix_pwm #(
    .ROWS(3), .COLS(4), .BITS(2), .SCAN_DIV(1), .BLANK(0)
  ) dut_oor (
    .clk(clk), .rst(rst), .wr_en(o_wr_en), .wr_addr(o_wr_addr), .wr_data(o_wr_data),
    .swap_req(o_swap_req), .swap_ack(o_swap_ack), .frame_sync(o_frame_sync),
    .aled(o_aled), .kled_tri(o_kled)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    o_wr_en = 1'b0; o_wr_addr = '0; o_wr_data = '0; o_swap_req = 1'b0;
  endtask

  // One clock: predict outputs from the model, advance the model, clock, compare.
  task automatic step(input string tag);
    logic [3:0] e_aled, e_kled, e_oa;
    logic [2:0] e_ok;
    logic       e_ack, e_sync;
    int         s, r, orow;
    e_aled = 4'hF; e_kled = 4'h0; e_ack = 1'b0; e_sync = 1'b0;
    e_oa = 4'hF; e_ok = 3'b000;
    if (!rst) begin
      s = (t / SCAN_DIV) % NSLOT;
      r = (t / ROW_CLK) % ROWS;
      if (s >= BLANK) begin
        e_kled = 4'(1 << r);
        for (int c = 0; c < COLS; c++)
          if (int'(m_buf[m_sel][r * COLS + c]) > s - BLANK) e_aled[c] = 1'b0;
      end
      e_sync = ((t % FRAME_CLK) == FRAME_CLK - 1);
      e_ack  = e_sync && (m_pend || swap_req);
      orow   = (t / O_ROW_CLK) % 3;
      e_ok   = 3'(1 << orow);
      if (oor_swapped && orow == 2) e_oa = 4'b0111;
    end
    if (rst) begin
      for (int i = 0; i < NLED; i++) begin m_buf[0][i] = '0; m_buf[1][i] = '0; end
      t = 0; m_sel = 0; m_pend = 1'b0; oor_pend = 1'b0; oor_swapped = 1'b0;
    end else begin
      if (wr_en && int'(wr_addr) < NLED) m_buf[1 - m_sel][wr_addr] = wr_data;
      if (e_ack) begin m_sel = 1 - m_sel; m_pend = 1'b0; end
      else m_pend = m_pend | swap_req;
      oor_pend = oor_pend | o_swap_req;
      if ((t % O_FRAME_CLK) == O_FRAME_CLK - 1 && oor_pend) begin
        oor_swapped = 1'b1; oor_pend = 1'b0;
      end
      t++;
    end
    @(posedge clk);
    #1;
    chk({tag, " aled"}, 32'(aled), 32'(e_aled));
    chk({tag, " kled_tri"}, 32'(kled_tri), 32'(e_kled));
    chk({tag, " swap_ack"}, 32'(swap_ack), 32'(e_ack));
    chk({tag, " frame_sync"}, 32'(frame_sync), 32'(e_sync));
    chk({tag, " oor aled"}, 32'(o_aled), 32'(e_oa));
    chk({tag, " oor kled_tri"}, 32'(o_kled), 32'(e_ok));
    if (swap_ack) n_ack++;
    if (frame_sync) n_sync++;
    for (int rr = 0; rr < ROWS; rr++)
      for (int c = 0; c < COLS; c++)
        if (kled_tri[rr] && !aled[c]) lit[rr * COLS + c]++;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic run_until(input int phase, input string tag);
    for (int i = 0; i < FRAME_CLK && (t % FRAME_CLK) != phase; i++) step(tag);
  endtask

  task automatic clear_lit();
    for (int i = 0; i < NLED; i++) lit[i] = 0;
  endtask

  task automatic wr(input int addr, input int data, input string tag);
    wr_en = 1'b1; wr_addr = 4'(addr); wr_data = 4'(data);
    step(tag);
    idle();
  endtask

  initial begin
    idle();
    t = 0; n_ack = 0; n_sync = 0;
    clear_lit();

    // 1: reset, then three idle frames
    rst = 1'b1;
    run(3, "reset");
    rst = 1'b0;
    n_ack = 0; n_sync = 0;
    run(3 * FRAME_CLK, "t1_idle");
    chk("t1_sync_count", 32'(n_sync), 32'd3);
    chk("t1_ack_count", 32'(n_ack), 32'd0);

    // 2: idx5=15, idx6=4, swap
    wr(5, 15, "t2_wr");
    wr(6, 4, "t2_wr");
    swap_req = 1'b1; step("t2_req"); idle();
    run_until(0, "t2_wait");
    clear_lit();
    run(FRAME_CLK, "t2_frame");
    chk("t2_lit_idx5", 32'(lit[5]), 32'd30);
    chk("t2_lit_idx6", 32'(lit[6]), 32'd8);
    chk("t2_lit_idx7", 32'(lit[7]), 32'd0);

    // 3: idx0=0, idx3=15, swap; old front is not copied
    wr(0, 0, "t3_wr");
    wr(3, 15, "t3_wr");
    swap_req = 1'b1; step("t3_req"); idle();
    run_until(0, "t3_wait");
    clear_lit();
    run(FRAME_CLK, "t3_frame");
    chk("t3_lit_idx3", 32'(lit[3]), 32'd30);
    chk("t3_lit_idx0", 32'(lit[0]), 32'd0);
    chk("t3_lit_idx5", 32'(lit[5]), 32'd0);

    // 4: swap_req and write idx2=9 on the frame-end cycle itself
    run_until(FRAME_CLK - 1, "t4_wait");
    swap_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'd9;
    step("t4_edge");
    idle();
    clear_lit();
    run(FRAME_CLK, "t4_frame");
    chk("t4_lit_idx2", 32'(lit[2]), 32'd18);
    chk("t4_lit_idx5", 32'(lit[5]), 32'd30);
    chk("t4_lit_idx3", 32'(lit[3]), 32'd0);

    // 5: out-of-range addresses on the 12-LED instance are dropped
    for (int a = 12; a < 16; a++) begin
      o_wr_en = 1'b1; o_wr_addr = 4'(a); o_wr_data = 2'd3;
      step("t5_oor_wr");
    end
    o_wr_en = 1'b1; o_wr_addr = 4'd11; o_wr_data = 2'd3;
    step("t5_wr11");
    idle();
    o_swap_req = 1'b1; step("t5_req"); idle();
    run(2 * FRAME_CLK, "t5_run");

    // randomized writes and swap requests
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom);
      wr_data  = 4'($urandom);
      swap_req = ($urandom_range(0, 63) == 0);
      step("rand");
    end
    idle();
    run(FRAME_CLK, "rand_tail");

    // 6: reset mid-row 2 with a swap pending
    run_until(0, "t6_wait");
    swap_req = 1'b1; step("t6_req"); idle();
    run_until(2 * ROW_CLK + 10, "t6_mid");
    rst = 1'b1;
    step("t6_rst");
    rst = 1'b0;
    n_ack0 = n_ack;
    run(2 * FRAME_CLK, "t6_after");
    chk("t6_no_ack", 32'(n_ack - n_ack0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
